// File: rtl/mem_tagged_responder_if.sv
// Tagged split-transaction memory bus between the cache/bus arbiter (master)
// and the memory responder (slave).
interface mem_tagged_responder_if #(
  parameter int XLEN = 32
);
  // A request is taken in the cycle its command is presented and response != 0
  // (response 0 means refused, so the initiator retries). A completion is a
  // one-cycle pulse with tag != 0. The return path cannot be stalled.
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/mem_tagged_responder.sv
// Memory-side responder that grants tags, holds requests for a fixed latency and returns tag plus data.
// Optional feature MEM_BACKPRESSURE_EN: an LFSR randomly refuses requests so initiator retry paths get exercised.
module mem_tagged_responder #(
  parameter int MEM_LATENCY = 20,
  parameter int NUM_TAGS    = 15,
  parameter int MEM_WORDS   = 8192,
  parameter int XLEN        = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_tagged_responder_if.slave bus
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  // A tag is emitted at the edge where its counter is already zero, which is one
  // edge before the completion cycle; latency 1 bypasses the counter entirely.
  localparam bit DIRECT = (MEM_LATENCY == 1);
  localparam logic [CW-1:0] CNT_INIT = CW'((MEM_LATENCY >= 2) ? MEM_LATENCY - 2 : 0);

  logic [63:0]     mem [MEM_WORDS];
  logic [NUM_TAGS:1] busy;
  logic [NUM_TAGS:1] pending;
  logic [CW-1:0]   cnt      [1:NUM_TAGS];
  logic [63:0]     tag_data [1:NUM_TAGS];
  logic [3:0]      tag_q;
  logic [63:0]     data_q;

  logic [XLEN-1:0] idx_full;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic            is_cmd;
  logic            is_load;
  logic            is_store;
  logic            accept;
  logic            bp_block;
  logic [3:0]      free_tag;
  logic [63:0]     new_data;
  logic [3:0]      emit_tag;
  logic [63:0]     emit_data;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^bus.proc2mem_addr[2:0];

  assign idx_full = {3'b000, bus.proc2mem_addr[XLEN-1:3]};
  assign idx      = bus.proc2mem_addr[AW+2:3];
  assign in_range = idx_full < XLEN'(MEM_WORDS);
  assign is_load  = bus.proc2mem_command == BUS_LOAD;
  assign is_store = bus.proc2mem_command == BUS_STORE;
  assign is_cmd   = is_load || is_store;

`ifdef MEM_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign bp_block = lfsr[1:0] == 2'b00;
`else
  assign bp_block = 1'b0;
`endif

  always_comb begin
    free_tag = 4'd0;
    for (int t = NUM_TAGS; t >= 1; t--) begin
      if (!busy[t]) free_tag = 4'(t);
    end
  end

  assign accept   = is_cmd && !reset && in_range && (free_tag != 4'd0) && !bp_block;
  assign new_data = is_load ? mem[idx] : 64'd0;

  assign bus.mem2proc_response = accept ? free_tag : 4'd0;
  assign bus.mem2proc_tag      = tag_q;
  assign bus.mem2proc_data     = data_q;

  // Fixed latency and one accept per cycle guarantee at most one tag matches here.
  always_comb begin
    emit_tag  = 4'd0;
    emit_data = 64'd0;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (busy[t] && pending[t] && cnt[t] == '0) begin
        emit_tag  = 4'(t);
        emit_data = tag_data[t];
      end
    end
    if (DIRECT && accept) begin
      emit_tag  = free_tag;
      emit_data = new_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy    <= '0;
      pending <= '0;
      tag_q   <= 4'd0;
      data_q  <= 64'd0;
      for (int t = 1; t <= NUM_TAGS; t++) cnt[t] <= '0;
    end else begin
      tag_q  <= emit_tag;
      data_q <= emit_data;
      for (int t = 1; t <= NUM_TAGS; t++) begin
        if (tag_q == 4'(t)) busy[t] <= 1'b0;
        if (busy[t] && pending[t]) begin
          if (cnt[t] == '0) pending[t] <= 1'b0;
          else              cnt[t]     <= cnt[t] - 1'b1;
        end
        if (accept && free_tag == 4'(t)) begin
          busy[t]    <= 1'b1;
          pending[t] <= !DIRECT;
          cnt[t]     <= CNT_INIT;
        end
      end
    end
  end

  // Storage and tag buffers keep their contents across reset.
  always_ff @(posedge clock) begin
    if (accept && is_store) mem[idx] <= bus.proc2mem_data;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (accept && free_tag == 4'(t)) tag_data[t] <= new_data;
    end
  end

endmodule

// File: tb/tb_mem_tagged_responder.sv
// Scoreboard bench for mem_tagged_responder: drivers push expected completions, a monitor pops and compares.
module tb_mem_tagged_responder;

`ifdef MEM_BACKPRESSURE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 20;
`endif
  localparam int W = 100;
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;

  logic clock;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  logic [15:0] lfsr_m;
  logic [W-1:0] exp_q[$];

  mem_tagged_responder_if #(.XLEN(32)) bus ();

  mem_tagged_responder #(
    .MEM_LATENCY(LAT),
    .NUM_TAGS(15),
    .MEM_WORDS(8192),
    .XLEN(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks: called just after a posedge, leave just after the next one
  task automatic issue(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] d,
                       input logic [3:0] exp_resp, input logic [63:0] exp_d, input bit want);
    bus.proc2mem_command = cmd;
    bus.proc2mem_addr    = addr;
    bus.proc2mem_data    = d;
    @(negedge clock);
    check("response", 64'(bus.mem2proc_response), 64'(exp_resp));
    if (want && exp_resp != 4'd0) exp_q.push_back({exp_resp, exp_d, 32'(cyc + LAT)});
    @(posedge clock);
    #1;
    bus.proc2mem_command = CMD_NONE;
  endtask

  task automatic idle(input int n);
    bus.proc2mem_command = CMD_NONE;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse(input int n);
    reset = 1'b1;
    bus.proc2mem_command = CMD_LOAD;
    bus.proc2mem_addr    = 32'h10;
    repeat (n) begin
      @(negedge clock);
      check("response_in_reset", 64'(bus.mem2proc_response), 64'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.proc2mem_command = CMD_NONE;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (mon_en && bus.mem2proc_tag !== 4'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_completion: got tag %h data %h expected no completion (cycle %0d)",
                 bus.mem2proc_tag, bus.mem2proc_data, cyc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("done_tag",   64'(bus.mem2proc_tag), 64'(e[99:96]));
        check("done_data",  bus.mem2proc_data,     e[95:32]);
        check("done_cycle", 64'(cyc),              64'(e[31:0]));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.proc2mem_command = CMD_LOAD;
    bus.proc2mem_addr    = 32'h0;
    bus.proc2mem_data    = 64'd0;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("reset_response", 64'(bus.mem2proc_response), 64'd0);
    check("reset_tag",      64'(bus.mem2proc_tag),      64'd0);
    check("reset_data",     bus.mem2proc_data,          64'd0);
    mon_en = 1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.proc2mem_command = CMD_NONE;
    idle(1);

`ifdef MEM_BACKPRESSURE_EN
    begin
      int  busy_until [1:15];
      bit  stored;
      int  c;
      logic [3:0] er;
      for (int t = 1; t <= 15; t++) busy_until[t] = -1;
      stored = 0;
      for (int i = 0; i < 200; i++) begin
        c  = cyc;
        er = 4'd0;
        if (lfsr_m[1:0] != 2'b00) begin
          for (int t = 15; t >= 1; t--) if (busy_until[t] < c) er = 4'(t);
        end
        if (stored) issue(CMD_LOAD,  32'h0, 64'd0,       er, 64'hC0FFEE, 1);
        else        issue(CMD_STORE, 32'h0, 64'hC0FFEE, er, 64'd0,      1);
        if (er != 4'd0) begin
          busy_until[er] = c + LAT;
          stored = 1;
        end
      end
      idle(LAT + 2);
    end
`else
    // preload word 2 through the bus, then a single load
    issue(CMD_STORE, 32'h10, DEAD, 4'd1, 64'd0, 1);
    idle(LAT + 1);
    issue(CMD_LOAD, 32'h10, 64'd0, 4'd1, DEAD, 1);
    idle(LAT + 1);

    // tag exhaustion and reuse timing
    for (int i = 0; i < 16; i++) begin
      issue(CMD_LOAD, 32'h10, 64'd0, (i < 15) ? 4'(i + 1) : 4'd0, DEAD, 1);
    end
    idle(4);
    issue(CMD_LOAD, 32'h10, 64'd0, 4'd0, DEAD, 1);
    issue(CMD_LOAD, 32'h10, 64'd0, 4'd1, DEAD, 1);
    idle(LAT + 2);

    // store then load of the same word, and load snapshot vs later store
    issue(CMD_STORE, 32'h40, 64'h5A5A, 4'd1, 64'd0,    1);
    issue(CMD_LOAD,  32'h44, 64'd0,    4'd2, 64'h5A5A, 1);
    issue(CMD_LOAD,  32'h40, 64'd0,    4'd3, 64'h5A5A, 1);
    issue(CMD_STORE, 32'h40, 64'h1234, 4'd4, 64'd0,    1);
    issue(CMD_LOAD,  32'h40, 64'd0,    4'd5, 64'h1234, 1);
    idle(LAT + 2);

    // reset discards in-flight requests
    issue(CMD_LOAD, 32'h10, 64'd0, 4'd1, DEAD, 0);
    issue(CMD_LOAD, 32'h10, 64'd0, 4'd2, DEAD, 0);
    issue(CMD_LOAD, 32'h10, 64'd0, 4'd3, DEAD, 0);
    idle(2);
    reset_pulse(1);
    issue(CMD_LOAD, 32'h10, 64'd0, 4'd1, DEAD, 1);
    idle(LAT + 2);

    // address range and illegal command
    issue(CMD_LOAD,  32'h10000, 64'd0,  4'd0, 64'd0,  1);
    issue(CMD_STORE, 32'h10008, 64'h99, 4'd0, 64'd0,  1);
    issue(2'b11,     32'h0,     64'd0,  4'd0, 64'd0,  1);
    issue(CMD_STORE, 32'hFFF8,  64'h77, 4'd1, 64'd0,  1);
    issue(CMD_LOAD,  32'hFFF8,  64'd0,  4'd2, 64'h77, 1);
    idle(LAT + 2);
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
